axi_lite_arbiter: RTL and testbench

AXI_LITE_ARBITER -- requirements
Module: axi_lite_arbiter

---
 rtl/axi_lite_arbiter.sv | 239 +++++++++++++++++++++++
 tb/tb_axi_lite_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : axi_lite_arbiter
// Brief    : Arbitrates an IFU read port and an LSU read/write port onto one
//            AXI4-Lite slave, one outstanding transaction at a time.
//            Define ARB_ROUND_ROBIN_EN for round-robin IFU/LSU arbitration.
// Revision : 1.0 - initial release
// =============================================================================
module axi_lite_arbiter (
    input  logic        clk,
    input  logic        rst,
    // IFU read
    input  logic [31:0] ifu_araddr,
    input  logic        ifu_arvalid,
    output logic        ifu_arready,
    output logic [31:0] ifu_rdata,
    output logic [1:0]  ifu_rresp,
    output logic        ifu_rvalid,
    input  logic        ifu_rready,
    // LSU read
    input  logic [31:0] lsu_araddr,
    input  logic        lsu_arvalid,
    output logic        lsu_arready,
    output logic [31:0] lsu_rdata,
    output logic [1:0]  lsu_rresp,
    output logic        lsu_rvalid,
    input  logic        lsu_rready,
    // LSU write
    input  logic [31:0] lsu_awaddr,
    input  logic        lsu_awvalid,
    output logic        lsu_awready,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wstrb,
    input  logic        lsu_wvalid,
    output logic        lsu_wready,
    output logic [1:0]  lsu_bresp,
    output logic        lsu_bvalid,
    input  logic        lsu_bready,
    // Memory slave
    output logic [31:0] m_araddr,
    output logic        m_arvalid,
    input  logic        m_arready,
    input  logic [31:0] m_rdata,
    input  logic [1:0]  m_rresp,
    input  logic        m_rvalid,
    output logic        m_rready,
    output logic [31:0] m_awaddr,
    output logic        m_awvalid,
    input  logic        m_awready,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    output logic        m_wvalid,
    input  logic        m_wready,
    input  logic [1:0]  m_bresp,
    input  logic        m_bvalid,
    output logic        m_bready
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RADDR = 3'd1,
        RDATA = 3'd2,
        WADDR = 3'd3,
        WRESP = 3'd4
    } state_t;

    localparam logic c_OWNER_IFU = 1'b0;
    localparam logic c_OWNER_LSU = 1'b1;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_owner;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_aw_done;
    logic        r_w_done;

    logic        w_wr_req;
    logic        w_lsu_req;
    logic        w_lsu_wins;
    logic        w_idle;
    logic        w_grant_ifu;
    logic        w_grant_lsu_rd;
    logic        w_grant_lsu_wr;
    logic        w_aw_fin;
    logic        w_w_fin;

    assign w_wr_req  = lsu_awvalid & lsu_wvalid;
    assign w_lsu_req = w_wr_req | lsu_arvalid;

`ifdef ARB_ROUND_ROBIN_EN
    logic r_last_grant;

    // On contention the master that was not served last wins.
    assign w_lsu_wins = w_lsu_req & (~ifu_arvalid | (r_last_grant == c_OWNER_IFU));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_grant <= c_OWNER_LSU;
        end else if (w_grant_ifu) begin
            r_last_grant <= c_OWNER_IFU;
        end else if (w_grant_lsu_rd | w_grant_lsu_wr) begin
            r_last_grant <= c_OWNER_LSU;
        end
    end
`else
    assign w_lsu_wins = w_lsu_req;
`endif

    // Grants are gated by rst so no ready escapes while reset is held.
    assign w_idle         = (r_state == IDLE) & rst;
    assign w_grant_lsu_wr = w_idle & w_lsu_wins & w_wr_req;
    assign w_grant_lsu_rd = w_idle & w_lsu_wins & ~w_wr_req;
    assign w_grant_ifu    = w_idle & ~w_lsu_wins & ifu_arvalid;

    assign ifu_arready = w_grant_ifu;
    assign lsu_arready = w_grant_lsu_rd;
    assign lsu_awready = w_grant_lsu_wr;
    assign lsu_wready  = w_grant_lsu_wr;

    assign m_araddr = r_addr;
    assign m_awaddr = r_addr;
    assign m_wdata  = r_wdata;
    assign m_wstrb  = r_wstrb;

    assign w_aw_fin = r_aw_done | m_awready;
    assign w_w_fin  = r_w_done | m_wready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        m_arvalid    = 1'b0;
        m_rready     = 1'b0;
        m_awvalid    = 1'b0;
        m_wvalid     = 1'b0;
        m_bready     = 1'b0;
        ifu_rvalid   = 1'b0;
        ifu_rdata    = '0;
        ifu_rresp    = '0;
        lsu_rvalid   = 1'b0;
        lsu_rdata    = '0;
        lsu_rresp    = '0;
        lsu_bvalid   = 1'b0;
        lsu_bresp    = '0;
        case (r_state)
            IDLE: begin
                if (w_grant_lsu_wr) begin
                    w_state_next = WADDR;
                end else if (w_grant_lsu_rd | w_grant_ifu) begin
                    w_state_next = RADDR;
                end
            end
            RADDR: begin
                m_arvalid = 1'b1;
                if (m_arready) begin
                    w_state_next = RDATA;
                end
            end
            RDATA: begin
                if (r_owner == c_OWNER_IFU) begin
                    ifu_rvalid = m_rvalid;
                    ifu_rdata  = m_rdata;
                    ifu_rresp  = m_rresp;
                    m_rready   = ifu_rready;
                end else begin
                    lsu_rvalid = m_rvalid;
                    lsu_rdata  = m_rdata;
                    lsu_rresp  = m_rresp;
                    m_rready   = lsu_rready;
                end
                if (m_rvalid & m_rready) begin
                    w_state_next = IDLE;
                end
            end
            WADDR: begin
                m_awvalid = ~r_aw_done;
                m_wvalid  = ~r_w_done;
                if (w_aw_fin & w_w_fin) begin
                    w_state_next = WRESP;
                end
            end
            WRESP: begin
                lsu_bvalid = m_bvalid;
                lsu_bresp  = m_bresp;
                m_bready   = lsu_bready;
                if (m_bvalid & lsu_bready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_owner   <= c_OWNER_IFU;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            if (w_grant_lsu_wr) begin
                r_owner <= c_OWNER_LSU;
                r_addr  <= lsu_awaddr;
                r_wdata <= lsu_wdata;
                r_wstrb <= lsu_wstrb;
            end else if (w_grant_lsu_rd) begin
                r_owner <= c_OWNER_LSU;
                r_addr  <= lsu_araddr;
            end else if (w_grant_ifu) begin
                r_owner <= c_OWNER_IFU;
                r_addr  <= ifu_araddr;
            end
            // AW and W complete independently; flags clear as the pair retires.
            if (r_state == WADDR) begin
                if (w_aw_fin & w_w_fin) begin
                    r_aw_done <= 1'b0;
                    r_w_done  <= 1'b0;
                end else begin
                    if (m_awready) r_aw_done <= 1'b1;
                    if (m_wready)  r_w_done  <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_arbiter.sv
`default_nettype none
// Self-checking bench for axi_lite_arbiter: directed steps, a scoreboard of
// expected responses, and a small behavioural memory slave.
`timescale 1ns/1ps
module tb_axi_lite_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ifu_araddr, ifu_rdata, lsu_araddr, lsu_rdata, lsu_awaddr, lsu_wdata;
    logic        ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready;
    logic        lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready;
    logic        lsu_awvalid, lsu_awready, lsu_wvalid, lsu_wready, lsu_bvalid, lsu_bready;
    logic [1:0]  ifu_rresp, lsu_rresp, lsu_bresp, m_rresp, m_bresp;
    logic [3:0]  lsu_wstrb, m_wstrb;
    logic [31:0] m_araddr, m_rdata, m_awaddr, m_wdata;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;

    axi_lite_arbiter dut (
        .clk(clk), .rst(rst),
        .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
        .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
        .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
        .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
        .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready),
        .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready),
        .lsu_bresp(lsu_bresp), .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_lsu;
        logic        is_wr;
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;

    exp_t sb_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   cyc = 0;
    int   n_ar = 0, n_aw = 0, n_w = 0, n_b = 0;
    int   aw_hs_cyc = 0, w_hs_cyc = 0;
    int   grant_src[$];
    int   grant_cyc[$];
    int   rhs_cyc[$];

    // Slave configuration and captured requests
    int          sl_ar_wait = 1, sl_r_wait = 2, sl_aw_wait = 1, sl_w_wait = 1, sl_b_wait = 1;
    logic [1:0]  sl_rresp = 2'b00, sl_bresp = 2'b00;
    logic [31:0] sl_cap_araddr, sl_cap_awaddr, sl_cap_wdata;
    logic [3:0]  sl_cap_wstrb;
    int          rd_phase, rd_cnt, aw_cnt, w_cnt, b_cnt;
    logic        aw_got, w_got;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h0000_0413;
        return a ^ 32'hA5A5_A5A5;
    endfunction

    function automatic logic [11:0] ctrl_vec();
        return {ifu_arready, ifu_rvalid, lsu_arready, lsu_rvalid, lsu_awready, lsu_wready,
                lsu_bvalid, m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready};
    endfunction

    function automatic logic data_any();
        return |{ifu_rdata, ifu_rresp, lsu_rdata, lsu_rresp, lsu_bresp,
                 m_araddr, m_awaddr, m_wdata, m_wstrb};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic is_lsu, input logic is_wr,
                            input logic [31:0] data, input logic [1:0] resp);
        exp_t e;
        e.is_lsu = is_lsu; e.is_wr = is_wr; e.data = data; e.resp = resp;
        sb_q.push_back(e);
    endtask

    // Memory slave; reset by the same rst as the arbiter.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_arready <= 1'b0; m_rvalid <= 1'b0; m_rdata <= '0; m_rresp <= '0;
            m_awready <= 1'b0; m_wready <= 1'b0; m_bvalid <= 1'b0; m_bresp <= '0;
            rd_phase <= 0; rd_cnt <= 0; aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0;
            aw_got <= 1'b0; w_got <= 1'b0;
        end else begin
            case (rd_phase)
                0: if (m_arvalid && m_arready) begin
                       m_arready <= 1'b0; rd_phase <= 1; rd_cnt <= 0; sl_cap_araddr <= m_araddr;
                   end else if (m_arvalid) begin
                       if (rd_cnt >= sl_ar_wait) m_arready <= 1'b1; else rd_cnt <= rd_cnt + 1;
                   end
                1: if (rd_cnt >= sl_r_wait) begin
                       m_rvalid <= 1'b1; m_rdata <= mem_word(sl_cap_araddr); m_rresp <= sl_rresp;
                       rd_phase <= 2;
                   end else rd_cnt <= rd_cnt + 1;
                default: if (m_rready) begin
                       m_rvalid <= 1'b0; m_rdata <= '0; m_rresp <= '0; rd_phase <= 0; rd_cnt <= 0;
                   end
            endcase
            if (m_awvalid && m_awready) begin
                m_awready <= 1'b0; aw_got <= 1'b1; sl_cap_awaddr <= m_awaddr;
            end else if (m_awvalid && !aw_got) begin
                if (aw_cnt >= sl_aw_wait) m_awready <= 1'b1; else aw_cnt <= aw_cnt + 1;
            end
            if (m_wvalid && m_wready) begin
                m_wready <= 1'b0; w_got <= 1'b1; sl_cap_wdata <= m_wdata; sl_cap_wstrb <= m_wstrb;
            end else if (m_wvalid && !w_got) begin
                if (w_cnt >= sl_w_wait) m_wready <= 1'b1; else w_cnt <= w_cnt + 1;
            end
            if (aw_got && w_got && !m_bvalid) begin
                if (b_cnt >= sl_b_wait) begin m_bvalid <= 1'b1; m_bresp <= sl_bresp; end
                else b_cnt <= b_cnt + 1;
            end else if (m_bvalid && m_bready) begin
                m_bvalid <= 1'b0; m_bresp <= '0; aw_got <= 1'b0; w_got <= 1'b0;
                aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0;
            end
        end
    end

    // Monitor: values are stable at negedge; a valid/ready pair seen here
    // completes at the following posedge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                if (m_arvalid && m_arready) n_ar++;
                if (m_awvalid && m_awready) begin n_aw++; aw_hs_cyc = cyc; end
                if (m_wvalid && m_wready) begin n_w++; w_hs_cyc = cyc; end
                if (m_bvalid && m_bready) n_b++;
                if (m_rvalid && m_rready) rhs_cyc.push_back(cyc);
                if (ifu_arvalid && ifu_arready) begin grant_src.push_back(0); grant_cyc.push_back(cyc); end
                if (lsu_arvalid && lsu_arready) begin grant_src.push_back(1); grant_cyc.push_back(cyc); end
                if (ifu_rvalid && ifu_rready) begin
                    check("ifu_r_expected", sb_q.size() != 0, 1'b1);
                    if (sb_q.size() != 0) begin
                        e = sb_q.pop_front();
                        check("ifu_r_kind", {e.is_lsu, e.is_wr}, 2'b00);
                        check("ifu_rdata", ifu_rdata, e.data);
                        check("ifu_rresp", ifu_rresp, e.resp);
                        check("ifu_r_lsu_quiet", {lsu_rvalid, lsu_bvalid}, 2'b00);
                    end
                end
                if (lsu_rvalid && lsu_rready) begin
                    check("lsu_r_expected", sb_q.size() != 0, 1'b1);
                    if (sb_q.size() != 0) begin
                        e = sb_q.pop_front();
                        check("lsu_r_kind", {e.is_lsu, e.is_wr}, 2'b10);
                        check("lsu_rdata", lsu_rdata, e.data);
                        check("lsu_rresp", lsu_rresp, e.resp);
                        check("lsu_r_ifu_quiet", ifu_rvalid, 1'b0);
                    end
                end
                if (lsu_bvalid && lsu_bready) begin
                    check("lsu_b_expected", sb_q.size() != 0, 1'b1);
                    if (sb_q.size() != 0) begin
                        e = sb_q.pop_front();
                        check("lsu_b_kind", {e.is_lsu, e.is_wr}, 2'b11);
                        check("lsu_bresp", lsu_bresp, e.resp);
                        check("lsu_b_follows_m", m_bvalid, 1'b1);
                    end
                end
            end
        end
    end

    task automatic ifu_read(input logic [31:0] a, input int budget);
        bit ok = 0;
        ifu_araddr = a; ifu_arvalid = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (ifu_arready) begin ok = 1; break; end
        end
        check("ifu_ar_granted", ok, 1'b1);
        @(posedge clk); #1;
        ifu_arvalid = 1'b0; ifu_araddr = '0;
    endtask

    task automatic lsu_read(input logic [31:0] a, input int budget);
        bit ok = 0;
        lsu_araddr = a; lsu_arvalid = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (lsu_arready) begin ok = 1; break; end
        end
        check("lsu_ar_granted", ok, 1'b1);
        @(posedge clk); #1;
        lsu_arvalid = 1'b0; lsu_araddr = '0;
    endtask

    task automatic lsu_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        bit ok = 0;
        lsu_awaddr = a; lsu_wdata = d; lsu_wstrb = s;
        lsu_awvalid = 1'b1; lsu_wvalid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (lsu_awready) begin ok = 1; break; end
        end
        check("lsu_aw_granted", ok, 1'b1);
        check("lsu_wready_with_aw", lsu_wready, 1'b1);
        @(posedge clk); #1;
        lsu_awvalid = 1'b0; lsu_wvalid = 1'b0;
        lsu_awaddr = '0; lsu_wdata = '0; lsu_wstrb = '0;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        bit ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0) begin ok = 1; break; end
        end
        check({tag, "_drain"}, ok, 1'b1);
        if (!ok) sb_q.delete();
        @(posedge clk); #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic first_lsu;
        int   naw0, nw0, nb0;
        bit   got;

        rst = 1'b0;
        ifu_araddr = '0; ifu_rready = 1'b1;
        lsu_araddr = '0; lsu_rready = 1'b1; lsu_awaddr = '0; lsu_wdata = '0; lsu_wstrb = '0;
        lsu_bready = 1'b1;
        // Requests held during reset must not be granted.
        ifu_arvalid = 1'b1; lsu_arvalid = 1'b1; lsu_awvalid = 1'b1; lsu_wvalid = 1'b1;
        #2;
        check("reset_ctrl", ctrl_vec(), 12'h000);
        check("reset_data", data_any(), 1'b0);
        ifu_arvalid = 1'b0; lsu_arvalid = 1'b0; lsu_awvalid = 1'b0; lsu_wvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;

        // Simultaneous IFU and LSU reads.
`ifdef ARB_ROUND_ROBIN_EN
        first_lsu = 1'b0;
`else
        first_lsu = 1'b1;
`endif
        if (first_lsu) begin
            push_exp(1'b1, 1'b0, mem_word(32'h1000_0040), 2'b00);
            push_exp(1'b0, 1'b0, mem_word(32'h8000_0004), 2'b00);
        end else begin
            push_exp(1'b0, 1'b0, mem_word(32'h8000_0004), 2'b00);
            push_exp(1'b1, 1'b0, mem_word(32'h1000_0040), 2'b00);
        end
        fork
            ifu_read(32'h8000_0004, 60);
            lsu_read(32'h1000_0040, 60);
        join
        wait_drain("contend", 60);
        check("contend_grants", grant_src.size(), 2);
        check("contend_first", grant_src[0], {31'd0, first_lsu});
        check("contend_second", grant_src[1], {31'd0, ~first_lsu});
        check("contend_regrant_gap", grant_cyc[1], rhs_cyc[0] + 1);

        // IFU read with the slave answering after 3 cycles.
        sl_r_wait = 3;
        push_exp(1'b0, 1'b0, 32'h0000_0413, 2'b00);
        ifu_read(32'h8000_0000, 20);
        wait_drain("ifu_rd", 40);
        check("ifu_rd_slave_addr", sl_cap_araddr, 32'h8000_0000);

        // LSU write, AW accepted two cycles before W.
        sl_aw_wait = 0; sl_w_wait = 2; sl_bresp = 2'b00;
        naw0 = n_aw; nw0 = n_w; nb0 = n_b;
        push_exp(1'b1, 1'b1, 32'h0, 2'b00);
        lsu_write(32'h8000_0100, 32'hDEAD_BEEF, 4'hF);
        wait_drain("wr", 60);
        check("wr_aw_count", n_aw - naw0, 1);
        check("wr_w_count", n_w - nw0, 1);
        check("wr_b_count", n_b - nb0, 1);
        check("wr_w_after_aw", w_hs_cyc - aw_hs_cyc, 2);
        check("wr_slave_addr", sl_cap_awaddr, 32'h8000_0100);
        check("wr_slave_data", {sl_cap_wstrb, sl_cap_wdata}, {4'hF, 32'hDEAD_BEEF});
        check("wr_back_to_idle", ctrl_vec(), 12'h000);

        // W before AW, DECERR write response forwarded unchanged.
        sl_aw_wait = 2; sl_w_wait = 0; sl_bresp = 2'b11;
        push_exp(1'b1, 1'b1, 32'h0, 2'b11);
        lsu_write(32'h0000_0200, 32'h1234_5678, 4'h3);
        wait_drain("wr_decerr", 60);
        check("wr2_slave_data", {sl_cap_wstrb, sl_cap_wdata}, {4'h3, 32'h1234_5678});
        sl_bresp = 2'b00; sl_aw_wait = 1; sl_w_wait = 1;

        // SLVERR read response on the LSU port.
        sl_rresp = 2'b10;
        push_exp(1'b1, 1'b0, mem_word(32'h2000_0008), 2'b10);
        lsu_read(32'h2000_0008, 20);
        wait_drain("lsu_slverr", 40);
        sl_rresp = 2'b00;

        // Owner stalls rready for 5 cycles while the slave holds rvalid.
        lsu_rready = 1'b0;
        push_exp(1'b1, 1'b0, mem_word(32'h3000_0010), 2'b00);
        lsu_read(32'h3000_0010, 20);
        got = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (lsu_rvalid) begin got = 1; break; end
        end
        check("hold_rvalid_seen", got, 1'b1);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            check("hold_m_rready", m_rready, 1'b0);
            check("hold_lsu_rdata", {lsu_rvalid, lsu_rdata}, {1'b1, mem_word(32'h3000_0010)});
        end
        @(posedge clk); #1;
        lsu_rready = 1'b1;
        wait_drain("hold", 20);

        // Asynchronous reset while in RDATA.
        sl_r_wait = 8;
        naw0 = n_ar;
        ifu_read(32'h8000_0010, 20);
        got = 0;
        for (int i = 0; i < 20; i++) begin
            if (n_ar != naw0) begin got = 1; break; end
            @(negedge clk);
        end
        check("rst_mid_ar_done", got, 1'b1);
        @(posedge clk); #1;
        check("rst_mid_in_rdata", m_rready, 1'b1);
        #2 rst = 1'b0;
        #1;
        check("rst_mid_ctrl", ctrl_vec(), 12'h000);
        check("rst_mid_data", data_any(), 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        sl_r_wait = 2;
        @(posedge clk); #1;
        push_exp(1'b0, 1'b0, 32'h0000_0413, 2'b00);
        ifu_read(32'h8000_0000, 20);
        wait_drain("after_rst", 40);
        check("after_rst_slave_addr", sl_cap_araddr, 32'h8000_0000);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
